cpu_phase_sequencer: RTL and testbench

CPU_PHASE_SEQUENCER -- requirements
Module: cpu_phase_sequencer

---
 rtl/cpu_phase_sequencer_pkg.sv | 17 +
 rtl/bp_match.sv | 21 ++
 rtl/cpu_phase_sequencer.sv | 148 ++++++++++++++
 tb/tb_cpu_phase_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared definitions for the CPU phase sequencer: FSM state encoding and
// the debug-mode constants driven onto the mode input.
package cpu_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } seq_state_e;

  // mode input encoding; 2'b11 is treated the same as HOLD
  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;

endpackage

// File: rtl/bp_match.sv
// PC breakpoint comparator array: one equality comparator per slot, gated by
// the per-slot enable. Purely combinational.
module bp_match #(
  parameter int PCW    = 32,
  parameter int NUM_BP = 2
) (
  input  logic [PCW-1:0]        pc,
  input  logic [NUM_BP*PCW-1:0] bp_addr,
  input  logic [NUM_BP-1:0]     bp_en,
  output logic [NUM_BP-1:0]     match
);

  // compare the PC against every enabled slot
  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < NUM_BP; k++) begin
      match[k] = bp_en[k] && (bp_addr[k*PCW +: PCW] == pc);
    end
  end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-phase instruction sequencer with RUN / single-STEP / HALT debug
// control and sticky PC breakpoints. One phase is active per cycle; the last
// phase commits the instruction unless the memory stall holds it.
module cpu_phase_sequencer
  import cpu_phase_sequencer_pkg::*;
#(
  parameter int PHASES = 4,
  parameter int PCW    = 32,
  parameter int NUM_BP = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       step_req,
  input  logic                       resume,
  input  logic                       stall,
  input  logic [PCW-1:0]             pc,
  input  logic [NUM_BP*PCW-1:0]      bp_addr,
  input  logic [NUM_BP-1:0]          bp_en,
  output logic [PHASES-1:0]          phase_en,
  output logic [$clog2(PHASES)-1:0]  phase_idx,
  output logic                       fetch_en,
  output logic                       commit_en,
  output logic                       running,
  output logic                       halted,
  output logic [NUM_BP-1:0]          bp_hit,
  output logic [31:0]                instr_count
);

  localparam int PIW = $clog2(PHASES);
  localparam logic [PIW-1:0] LAST_PH = PIW'(PHASES - 1);

  seq_state_e        state_q, state_d;
  logic [PIW-1:0]    phase_q, phase_d;
  logic [31:0]       instr_count_q, instr_count_d;
  logic [NUM_BP-1:0] bp_hit_q, bp_hit_d;
  logic              bp_skip_q, bp_skip_d;

  logic [NUM_BP-1:0] bp_match_vec;
  logic              exec_state;
  logic              bp_fire;
  logic              active;
  logic              at_last;

  bp_match #(
    .PCW    (PCW),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .pc      (pc),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .match   (bp_match_vec)
  );

  // Breakpoints are only checked at the start of a RUN instruction; bp_skip
  // lets the instruction that caused the halt execute once after resume.
  always_comb begin
    exec_state = (state_q == ST_RUN) || (state_q == ST_STEP);
    at_last    = (phase_q == LAST_PH);
    bp_fire    = (state_q == ST_RUN) && (phase_q == '0) && !bp_skip_q && (|bp_match_vec);
    active     = exec_state && !bp_fire;
  end

  // next-state logic for the sequencer FSM, phase counter and debug state
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    instr_count_d = instr_count_q;
    bp_hit_d      = bp_hit_q;
    bp_skip_d     = bp_skip_q;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (mode == MODE_RUN) begin
          state_d = ST_RUN;
        end else if ((mode == MODE_STEP) && step_req) begin
          state_d = ST_STEP;
        end
      end

      ST_RUN, ST_STEP: begin
        if (bp_fire) begin
          bp_hit_d = bp_hit_q | bp_match_vec;
          phase_d  = '0;
          state_d  = ST_HALT;
        end else if (!stall) begin
          if (at_last) begin
            phase_d       = '0;
            instr_count_d = instr_count_q + 32'd1;
            bp_skip_d     = 1'b0;
            // mode is only sampled at the commit boundary in RUN
            if ((state_q == ST_STEP) || (mode != MODE_RUN)) begin
              state_d = ST_IDLE;
            end
          end else begin
            phase_d = phase_q + PIW'(1);
          end
        end
      end

      ST_HALT: begin
        if (resume) begin
          state_d   = ST_RUN;
          bp_skip_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // sequencer state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      instr_count_q <= '0;
      bp_hit_q      <= '0;
      bp_skip_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      instr_count_q <= instr_count_d;
      bp_hit_q      <= bp_hit_d;
      bp_skip_q     <= bp_skip_d;
    end
  end

  // output decode: one-hot phase enable suppressed on a breakpoint cycle
  always_comb begin
    phase_en = '0;
    for (int unsigned i = 0; i < PHASES; i++) begin
      phase_en[i] = active && (phase_q == PIW'(i));
    end
    fetch_en    = phase_en[0];
    commit_en   = phase_en[PHASES-1] & ~stall;
    phase_idx   = phase_q;
    running     = exec_state;
    halted      = (state_q == ST_HALT);
    bp_hit      = bp_hit_q;
    instr_count = instr_count_q;
  end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Self-checking bench for cpu_phase_sequencer: directed scenarios followed by
// randomized stimulus, with a behavioural model compared every cycle.
module tb_cpu_phase_sequencer;

  localparam int PHASES = 4;
  localparam int PCW    = 32;
  localparam int NUM_BP = 2;

  logic                  clk;
  logic                  rst;
  logic [1:0]            mode;
  logic                  step_req;
  logic                  resume;
  logic                  stall;
  logic [PCW-1:0]        pc;
  logic [PCW-1:0]        bp_slot [NUM_BP];
  logic [NUM_BP*PCW-1:0] bp_addr;
  logic [NUM_BP-1:0]     bp_en;
  logic [PHASES-1:0]     phase_en;
  logic [1:0]            phase_idx;
  logic                  fetch_en;
  logic                  commit_en;
  logic                  running;
  logic                  halted;
  logic [NUM_BP-1:0]     bp_hit;
  logic [31:0]           instr_count;

  assign bp_addr = {bp_slot[1], bp_slot[0]};

  cpu_phase_sequencer #(
    .PHASES (PHASES),
    .PCW    (PCW),
    .NUM_BP (NUM_BP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .step_req    (step_req),
    .resume      (resume),
    .stall       (stall),
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_en       (bp_en),
    .phase_en    (phase_en),
    .phase_idx   (phase_idx),
    .fetch_en    (fetch_en),
    .commit_en   (commit_en),
    .running     (running),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          chk_on = 1'b0;

  // behavioural model: what the sequencer is doing, in plain terms
  bit          m_free;   // free-running execution
  bit          m_step;   // executing a single-stepped instruction
  bit          m_halt;   // stopped at a breakpoint
  bit          m_skip;   // next phase-0 breakpoint check is waived
  int unsigned m_phase;
  logic [31:0] m_count;
  logic [NUM_BP-1:0] m_hits;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_BP-1:0] slots_hit();
    logic [NUM_BP-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_BP; k++) begin
      if (bp_en[k] && (bp_slot[k] == pc)) r[k] = 1'b1;
    end
    return r;
  endfunction

  function automatic bit bp_now();
    return m_free && (m_phase == 0) && !m_skip && (slots_hit() != '0);
  endfunction

  // advance the model on every clock edge
  always @(posedge clk) begin : model
    logic [NUM_BP-1:0] hv;
    bit fire;
    hv   = slots_hit();
    fire = bp_now();
    if (rst) begin
      m_free = 0; m_step = 0; m_halt = 0; m_skip = 0;
      m_phase = 0; m_count = '0; m_hits = '0;
    end else if (m_halt) begin
      if (resume) begin
        m_halt = 0; m_free = 1; m_skip = 1;
      end
    end else if (!m_free && !m_step) begin
      if (mode == 2'b00) m_free = 1;
      else if (mode == 2'b01 && step_req) m_step = 1;
    end else if (fire) begin
      m_hits = m_hits | hv;
      m_free = 0; m_halt = 1; m_phase = 0;
    end else if (!stall) begin
      if (m_phase == PHASES - 1) begin
        m_count = m_count + 32'd1;
        m_phase = 0;
        m_skip  = 0;
        if (m_step) m_step = 0;
        else if (mode != 2'b00) m_free = 0;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  end

  // compare every output against the model away from the active edge
  always @(negedge clk) begin : compare
    bit act;
    logic [PHASES-1:0] epe;
    if (chk_on) begin
      act = (m_free || m_step) && !bp_now();
      epe = act ? (PHASES'(1) << m_phase) : '0;
      chk("phase_en",    32'(phase_en),    32'(epe));
      chk("phase_idx",   32'(phase_idx),   m_phase);
      chk("fetch_en",    32'(fetch_en),    32'(epe[0]));
      chk("commit_en",   32'(commit_en),   32'(act && (m_phase == PHASES - 1) && !stall));
      chk("running",     32'(running),     32'(m_free || m_step));
      chk("halted",      32'(halted),      32'(m_halt));
      chk("bp_hit",      32'(bp_hit),      32'(m_hits));
      chk("instr_count", instr_count,      m_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  logic [31:0] pcs [4] = '{32'h10, 32'h20, 32'h40, 32'h44};

  initial begin
    rst = 1'b1; mode = 2'b10; step_req = 1'b0; resume = 1'b0; stall = 1'b0;
    pc = '0; bp_en = '0; bp_slot[0] = '0; bp_slot[1] = '0;
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_phase_en", 32'(phase_en), 32'd0);
    chk("rst_count",    instr_count,   32'd0);
    chk("rst_running",  32'(running),  32'd0);

    // free run: eight instructions, phase enables walk one-hot
    mode = 2'b00;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("run_phase_en", 32'(phase_en),  32'(4'b0001 << i));
      chk("run_commit",   32'(commit_en), 32'(i == 3));
      tick();
    end
    cyc(24);
    mode = 2'b10;
    cyc(4);
    #1;
    chk("run_count8",  instr_count,   32'd8);
    chk("run_to_idle", 32'(running),  32'd0);

    // stall held three cycles at the last phase
    mode = 2'b00;
    tick();
    cyc(3);
    stall = 1'b1;
    repeat (3) begin
      #1;
      chk("stall_idx",    32'(phase_idx), 32'd3);
      chk("stall_commit", 32'(commit_en), 32'd0);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("stall_release_commit", 32'(commit_en), 32'd1);
    tick();
    #1;
    chk("stall_count", instr_count,   32'd9);
    chk("stall_wrap",  32'(phase_idx), 32'd0);
    mode = 2'b10;
    cyc(4);
    #1;
    chk("stall_count_b", instr_count, 32'd10);

    // single step: two pulses, idle between them
    mode = 2'b01;
    cyc(3);
    #1;
    chk("step_wait_idle", 32'(running), 32'd0);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    #1;
    chk("step_running", 32'(running), 32'd1);
    cyc(4);
    #1;
    chk("step_idle1",  32'(running), 32'd0);
    chk("step_count1", instr_count,  32'd11);
    cyc(15);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    cyc(4);
    #1;
    chk("step_idle2",  32'(running), 32'd0);
    chk("step_count2", instr_count,  32'd12);

    // breakpoint at 0x10, then resume
    bp_slot[0] = 32'h10; bp_slot[1] = 32'h40; bp_en = 2'b01;
    pc = 32'h08; mode = 2'b00;
    tick();
    cyc(4);
    pc = 32'h10;
    #1;
    chk("bp_no_fetch",    32'(fetch_en), 32'd0);
    chk("bp_no_phase_en", 32'(phase_en), 32'd0);
    tick();
    #1;
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_hit",    32'(bp_hit), 32'd1);
    cyc(3);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    chk("bp_resume_fetch", 32'(fetch_en), 32'd1);
    cyc(4);
    pc = 32'h14;
    mode = 2'b10;
    #1;
    chk("bp_no_rehalt", 32'(halted),   32'd0);
    chk("bp_next_fetch", 32'(fetch_en), 32'd1);
    cyc(4);
    #1;
    chk("bp_count", instr_count, 32'd15);
    bp_en = 2'b00;

    // HOLD requested at phase 1 finishes the instruction first
    mode = 2'b00;
    tick();
    tick();
    mode = 2'b10;
    cyc(2);
    #1;
    chk("hold_commit", 32'(commit_en), 32'd1);
    tick();
    #1;
    chk("hold_idle",  32'(running), 32'd0);
    chk("hold_count", instr_count,  32'd16);

    // reset at phase 2 abandons the instruction
    mode = 2'b00;
    tick();
    cyc(2);
    rst = 1'b1;
    mode = 2'b10;
    #1;
    chk("rst_mid_commit", 32'(commit_en), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_phase_en", 32'(phase_en),  32'd0);
    chk("rst2_idx",      32'(phase_idx), 32'd0);
    chk("rst2_fetch",    32'(fetch_en),  32'd0);
    chk("rst2_running",  32'(running),   32'd0);
    chk("rst2_halted",   32'(halted),    32'd0);
    chk("rst2_bp_hit",   32'(bp_hit),    32'd0);
    chk("rst2_count",    instr_count,    32'd0);

    // instruction counter wrap
    force dut.instr_count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    mode = 2'b00;
    tick();
    cyc(3);
    mode = 2'b10;
    #1;
    chk("wrap_commit", 32'(commit_en), 32'd1);
    chk("wrap_pre",    instr_count,    32'hFFFF_FFFF);
    tick();
    #1;
    chk("wrap_count", instr_count, 32'd0);

    // randomized traffic
    bp_slot[0] = 32'h10; bp_slot[1] = 32'h40;
    for (int c = 0; c < 3000; c++) begin
      int unsigned r;
      r        = $urandom_range(0, 99);
      mode     = (r < 60) ? 2'b00 : (r < 80) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
      rst      = ($urandom_range(0, 199) == 0);
      step_req = ($urandom_range(0, 7) == 0);
      resume   = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      pc       = pcs[$urandom_range(0, 3)];
      if ((c % 50) == 0) bp_en = 2'($urandom_range(0, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
